// File: rtl/des_ks_pkg.sv
// rtl/des_ks_pkg.sv - shared constants, state enum and shift helper for the DES key sequencer
// Contents: KEY_W/HALF_W widths, default per-round shift mask, FSM state type,
//           shift_amt() returning the rotation amount (1 or 2) of a given round.
package des_ks_pkg;

  localparam int          KEY_W              = 56;
  localparam int          HALF_W             = 28;
  localparam logic [15:0] SHIFT_MASK_DEFAULT = 16'h7EFC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Rotation applied by encrypt round idx: 2 where the mask bit is set, else 1.
  function automatic logic [1:0] shift_amt(input logic [15:0] mask, input logic [3:0] idx);
    return mask[idx] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/des_ks_rotator.sv
// rtl/des_ks_rotator.sv - combinational 28-bit rotate by 0, 1 or 2 in either direction
// Ports: i_din   half-key in
//        i_amt   rotation amount (0, 1 or 2; 3 treated as 0)
//        i_right 1 = rotate right, 0 = rotate left
//        o_dout  rotated half-key
module des_ks_rotator
  import des_ks_pkg::*;
(
  input  logic [HALF_W-1:0] i_din,
  input  logic [1:0]        i_amt,
  input  logic              i_right,
  output logic [HALF_W-1:0] o_dout
);

  always_comb begin
    o_dout = i_din;
    case (i_amt)
      2'd1: o_dout = i_right ? {i_din[0], i_din[HALF_W-1:1]}
                             : {i_din[HALF_W-2:0], i_din[HALF_W-1]};
      2'd2: o_dout = i_right ? {i_din[1:0], i_din[HALF_W-1:2]}
                             : {i_din[HALF_W-3:0], i_din[HALF_W-1:HALF_W-2]};
      default: o_dout = i_din;
    endcase
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - DES key-state sequencer: one PC-1 key in, 16 rotated C||D states out
// Ports: i_clk/i_rst                 clock, async active-high reset
//        i_start_valid/o_start_ready key load handshake (ready only when idle)
//        i_key, i_decrypt            PC-1 key and direction, sampled on acceptance
//        i_abort                     cancel the running operation
//        o_rk_valid/i_rk_ready       round output handshake
//        o_rk_cd, o_rk_round         rotated key-state and its round index
//        o_rk_last                   final round flag, o_busy = not idle
module des_key_sched_ctrl
  import des_ks_pkg::*;
#(
  parameter logic [15:0] SHIFT_MASK = SHIFT_MASK_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_decrypt,
  input  logic             i_abort,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic [KEY_W-1:0] o_rk_cd,
  output logic [3:0]       o_rk_round,
  output logic             o_rk_last,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_cd;
  logic [3:0]       r_round;
  logic             r_valid;
  logic             r_dec;

  logic             w_accept;
  logic             w_advance;
  logic             w_last_round;
  logic [KEY_W-1:0] w_rot_src;
  logic [KEY_W-1:0] w_rot_out;
  logic [1:0]       w_amt;
  logic             w_right;

  assign w_last_round = (r_round == 4'd15);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority; a coincident handshake is dropped.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_valid && i_rk_ready) begin
          if (w_last_round) w_state_nxt = ST_IDLE;
          else              w_advance   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One rotator pair serves both the round-0 load (from i_key) and each advance
  // (from r_cd). Decrypt round 0 is the raw key, so it uses amount 0. Decrypt
  // advances walk the encrypt schedule backwards: round r+1 undoes shift(15-r).
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_rot_src = i_key;
      w_right   = 1'b0;
      w_amt     = i_decrypt ? 2'd0 : shift_amt(SHIFT_MASK, 4'd0);
    end else begin
      w_rot_src = r_cd;
      w_right   = r_dec;
      w_amt     = r_dec ? shift_amt(SHIFT_MASK, 4'd15 - r_round)
                        : shift_amt(SHIFT_MASK, r_round + 4'd1);
    end
  end

  des_ks_rotator u_rot_c (
    .i_din   (w_rot_src[KEY_W-1:HALF_W]),
    .i_amt   (w_amt),
    .i_right (w_right),
    .o_dout  (w_rot_out[KEY_W-1:HALF_W])
  );

  des_ks_rotator u_rot_d (
    .i_din   (w_rot_src[HALF_W-1:0]),
    .i_amt   (w_amt),
    .i_right (w_right),
    .o_dout  (w_rot_out[HALF_W-1:0])
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cd    <= w_rot_out;
        r_round <= 4'd0;
        r_valid <= 1'b1;
        r_dec   <= i_decrypt;
      end else if (w_advance) begin
        r_cd    <= w_rot_out;
        r_round <= r_round + 4'd1;
      end else if (r_state == ST_RUN && w_state_nxt == ST_IDLE) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_start_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_rk_valid    = r_valid;
  assign o_rk_cd       = r_cd;
  assign o_rk_round    = r_round;
  assign o_rk_last     = r_valid && w_last_round;

endmodule
